// File: rtl/stream_to_bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_to_bram_pkg
//  Purpose  : Shared types and helpers for the stream_to_bram capture block.
//  Revision : 1.0 - initial release
// ============================================================================
package stream_to_bram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE  = 2'd0,
        TRIG_ORBIT_SYNC = 2'd1,
        TRIG_EXT        = 2'd2,
        TRIG_RESERVED   = 2'd3
    } trig_mode_t;

    // A zero or oversized length means "fill the whole memory".
    function automatic logic [16:0] eff_len(input logic [15:0] cfg_length,
                                            input int unsigned mem_depth);
        logic [16:0] depth;
        logic [16:0] len;
        depth = mem_depth[16:0];
        len   = {1'b0, cfg_length};
        if ((len == 17'd0) || (len > depth))
            return depth;
        return len;
    endfunction

endpackage : stream_to_bram_pkg
`default_nettype wire

// File: rtl/stream_to_bram.sv
`default_nettype none
// ============================================================================
//  Module   : stream_to_bram
//  Purpose  : AXI-stream sink capturing 32-bit words into a BRAM write port,
//             armed by software, triggered immediately / orbitSync / ext_trig.
//  Options  : STREAM_TO_BRAM_CONTINUOUS_EN enables ring-buffer capture.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_to_bram
    import stream_to_bram_pkg::*;
#(
    parameter int MEM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        cfg_arm,
    input  logic        cfg_abort,
    input  logic [1:0]  cfg_trig_mode,
    input  logic [15:0] cfg_length,
    input  logic        cfg_continuous,
    input  logic        fc_orbitSync,
    input  logic        ext_trig,
    input  logic [31:0] data_stream_TDATA,
    input  logic        data_stream_TVALID,
    output logic        data_stream_TREADY,
    output logic        bram_CLK,
    output logic        bram_RST,
    output logic        bram_EN,
    output logic [3:0]  bram_WE,
    output logic [31:0] bram_ADDR,
    output logic [31:0] bram_DIN,
    output logic [1:0]  stat_state,
    output logic [15:0] stat_words,
    output logic        stat_done
);

    localparam int c_AW = $clog2(MEM_DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_tready;
    logic [c_AW-1:0] r_waddr;
    logic [16:0]     r_words;
    logic [16:0]     r_len;
    logic            r_bram_en;
    logic [3:0]      r_bram_we;
    logic [31:0]     r_bram_addr;
    logic [31:0]     r_bram_din;

    logic            w_trig;
    logic            w_accept;
    logic            w_clear;
    logic            w_last;
    logic            w_cont;
    logic            w_wrap;
    logic [c_AW-1:0] w_waddr_nxt;
    logic [16:0]     w_words_nxt;

`ifdef STREAM_TO_BRAM_CONTINUOUS_EN
    logic r_cont;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            r_cont <= 1'b0;
        else if (w_clear)
            r_cont <= cfg_continuous;
    end

    assign w_cont = r_cont;
`else
    logic w_cfg_continuous_unused;
    assign w_cfg_continuous_unused = cfg_continuous;
    assign w_cont = 1'b0;
`endif

    always_comb begin
        w_trig = 1'b1;
        case (trig_mode_t'(cfg_trig_mode))
            TRIG_ORBIT_SYNC: w_trig = fc_orbitSync;
            TRIG_EXT:        w_trig = ext_trig;
            default:         w_trig = 1'b1;
        endcase
    end

    assign w_last      = ((r_words + 17'd1) == r_len);
    assign w_wrap      = (({{(17-c_AW){1'b0}}, r_waddr} + 17'd1) == r_len);
    assign w_waddr_nxt = (w_cont && w_wrap) ? '0 : r_waddr + 1'b1;
    assign w_words_nxt = (w_cont && (r_words == r_len)) ? r_words : r_words + 17'd1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Abort outranks arm, which outranks the trigger; arm is only seen from
    // IDLE/DONE, so a trigger coincident with arm never reaches ARMED logic.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        if (cfg_abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (cfg_arm) begin
                        w_state_nxt = ARMED;
                        w_clear     = 1'b1;
                    end
                end
                ARMED: begin
                    if (w_trig) begin
                        w_accept = data_stream_TVALID && r_tready;
                        if (w_accept && w_last && !w_cont)
                            w_state_nxt = DONE;
                        else
                            w_state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    w_accept = data_stream_TVALID && r_tready;
                    if (w_accept && w_last && !w_cont)
                        w_state_nxt = DONE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_tready    <= 1'b0;
            r_waddr     <= '0;
            r_words     <= '0;
            r_len       <= '0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 4'h0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            r_tready  <= 1'b1;
            r_bram_en <= w_accept;
            r_bram_we <= {4{w_accept}};
            if (w_accept) begin
                r_bram_addr <= {{(30-c_AW){1'b0}}, r_waddr, 2'b00};
                r_bram_din  <= data_stream_TDATA;
                r_waddr     <= w_waddr_nxt;
                r_words     <= w_words_nxt;
            end
            if (w_clear) begin
                r_waddr <= '0;
                r_words <= '0;
                r_len   <= eff_len(cfg_length, MEM_DEPTH);
            end
        end
    end

    assign data_stream_TREADY = r_tready;
    assign bram_CLK           = clk;
    assign bram_RST           = ~aresetn;
    assign bram_EN            = r_bram_en;
    assign bram_WE            = r_bram_we;
    assign bram_ADDR          = r_bram_addr;
    assign bram_DIN           = r_bram_din;
    assign stat_state         = r_state;
    assign stat_words         = r_words[15:0];
    assign stat_done          = (r_state == DONE);

endmodule : stream_to_bram
`default_nettype wire

// File: tb/tb_stream_to_bram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_to_bram
//  Purpose  : Directed self-checking bench for stream_to_bram (MEM_DEPTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_to_bram;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_arm = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [1:0]  cfg_trig_mode = 2'd0;
    logic [15:0] cfg_length = 16'd0;
    logic        cfg_continuous = 1'b0;
    logic        fc_orbitSync = 1'b0;
    logic        ext_trig = 1'b0;
    logic [31:0] data_stream_TDATA = 32'd0;
    logic        data_stream_TVALID = 1'b0;
    logic        data_stream_TREADY;
    logic        bram_CLK, bram_RST, bram_EN;
    logic [3:0]  bram_WE;
    logic [31:0] bram_ADDR, bram_DIN;
    logic [1:0]  stat_state;
    logic [15:0] stat_words;
    logic        stat_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_to_bram #(.MEM_DEPTH(16)) dut (
        .clk(clk), .aresetn(aresetn),
        .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
        .cfg_trig_mode(cfg_trig_mode), .cfg_length(cfg_length),
        .cfg_continuous(cfg_continuous),
        .fc_orbitSync(fc_orbitSync), .ext_trig(ext_trig),
        .data_stream_TDATA(data_stream_TDATA),
        .data_stream_TVALID(data_stream_TVALID),
        .data_stream_TREADY(data_stream_TREADY),
        .bram_CLK(bram_CLK), .bram_RST(bram_RST), .bram_EN(bram_EN),
        .bram_WE(bram_WE), .bram_ADDR(bram_ADDR), .bram_DIN(bram_DIN),
        .stat_state(stat_state), .stat_words(stat_words), .stat_done(stat_done)
    );

    // BRAM model plus write log.
    logic [31:0] mem [0:15];
    logic [31:0] wr_addr [$];
    int          wr_cnt = 0;
    int          consec = 0;
    int          bad_we = 0;
    bit          prev_wr = 1'b0;

    always @(posedge clk) begin
        if (bram_EN || (bram_WE != 4'h0)) begin
            if (!(bram_EN && (bram_WE == 4'hF)))
                bad_we++;
            if (prev_wr)
                consec++;
            mem[bram_ADDR[5:2]] = bram_DIN;
            wr_addr.push_back(bram_ADDR);
            wr_cnt++;
            prev_wr = 1'b1;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] mode, input logic [15:0] len);
        cfg_trig_mode = mode;
        cfg_length    = len;
        cfg_arm       = 1'b1;
        step();
        cfg_arm       = 1'b0;
    endtask

    task automatic beat(input logic v, input logic [31:0] d);
        data_stream_TVALID = v;
        data_stream_TDATA  = d;
        step();
    endtask

    int base;
    int cbase;

    initial begin
        // Reset state
        step(3);
        chk("rst_tready", {31'd0, data_stream_TREADY}, 32'd0);
        chk("rst_en",     {31'd0, bram_EN}, 32'd0);
        chk("rst_we",     {28'd0, bram_WE}, 32'd0);
        chk("rst_addr",   bram_ADDR, 32'd0);
        chk("rst_state",  {30'd0, stat_state}, 32'd0);
        chk("rst_words",  {16'd0, stat_words}, 32'd0);
        chk("rst_bramrst", {31'd0, bram_RST}, 32'd1);
        aresetn = 1'b1;
        step();
        chk("tready_up",  {31'd0, data_stream_TREADY}, 32'd1);

        // 1: immediate, length 4; length change after arm must be ignored
        base = wr_cnt;
        arm(2'd0, 16'd4);
        chk("t1_armed", {30'd0, stat_state}, 32'd1);
        cfg_length = 16'd9;
        for (int i = 0; i < 6; i++) beat(1'b1, 32'hA0 + i);
        beat(1'b0, 32'h0);
        step(2);
        chk("t1_wrcnt", wr_cnt - base, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", wr_addr[base+i], 32'(i*4));
            chk("t1_data", mem[i], 32'hA0 + i);
        end
        chk("t1_done",  {31'd0, stat_done}, 32'd1);
        chk("t1_words", {16'd0, stat_words}, 32'd4);
        chk("t1_state", {30'd0, stat_state}, 32'd3);

        // 2: orbitSync trigger at beat 5
        base = wr_cnt;
        arm(2'd1, 16'd3);
        for (int i = 0; i < 10; i++) begin
            fc_orbitSync = (i == 5);
            beat(1'b1, 32'hB0 + i);
        end
        fc_orbitSync = 1'b0;
        beat(1'b0, 32'h0);
        step(2);
        chk("t2_wrcnt", wr_cnt - base, 32'd3);
        chk("t2_addr0", wr_addr[base], 32'h0);
        for (int i = 0; i < 3; i++) chk("t2_data", mem[i], 32'hB5 + i);
        chk("t2_keep3", mem[3], 32'hA3);

        // 3: ext_trig, gapped stream; trigger during the arm cycle is ignored
        base  = wr_cnt;
        cbase = consec;
        cfg_trig_mode = 2'd2;
        cfg_length    = 16'd4;
        cfg_arm = 1'b1; ext_trig = 1'b1;
        beat(1'b1, 32'hDEAD);
        cfg_arm = 1'b0; ext_trig = 1'b0;
        beat(1'b0, 32'h0);
        chk("t3_still_armed", {30'd0, stat_state}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            ext_trig = (i == 0);
            beat((i % 2) == 0, 32'hC0 + i);
        end
        ext_trig = 1'b0;
        beat(1'b0, 32'h0);
        step(2);
        chk("t3_wrcnt",  wr_cnt - base, 32'd4);
        chk("t3_nogap",  consec - cbase, 32'd0);
        for (int i = 0; i < 4; i++) chk("t3_data", mem[i], 32'hC0 + 2*i);
        chk("t3_done",   {31'd0, stat_done}, 32'd1);

        // 4: length 0 means full depth
        base = wr_cnt;
        arm(2'd0, 16'd0);
        for (int i = 0; i < 20; i++) beat(1'b1, 32'hD00 + i);
        beat(1'b0, 32'h0);
        step(2);
        chk("t4_wrcnt", wr_cnt - base, 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t4_addr", wr_addr[base+i], 32'(i*4));
            chk("t4_data", mem[i], 32'hD00 + i);
        end
        chk("t4_state", {30'd0, stat_state}, 32'd3);
        chk("t4_words", {16'd0, stat_words}, 32'd16);
        arm(2'd0, 16'd0);
        chk("t4_rearm_state", {30'd0, stat_state}, 32'd1);
        chk("t4_rearm_words", {16'd0, stat_words}, 32'd0);

        // 5a: abort after two words
        base = wr_cnt;
        beat(1'b1, 32'hE0);
        beat(1'b1, 32'hE1);
        cfg_abort = 1'b1;
        beat(1'b1, 32'hE2);
        cfg_abort = 1'b0;
        beat(1'b0, 32'h0);
        step(2);
        chk("t5_state", {30'd0, stat_state}, 32'd0);
        chk("t5_words", {16'd0, stat_words}, 32'd2);
        chk("t5_wrcnt", wr_cnt - base, 32'd2);

        // eff_len = 1 straight from ARMED to DONE
        base = wr_cnt;
        arm(2'd0, 16'd1);
        beat(1'b1, 32'hF1);
        chk("l1_state", {30'd0, stat_state}, 32'd3);
        beat(1'b1, 32'hF2);
        beat(1'b0, 32'h0);
        step(2);
        chk("l1_wrcnt", wr_cnt - base, 32'd1);
        chk("l1_data",  mem[0], 32'hF1);
        chk("l1_words", {16'd0, stat_words}, 32'd1);

        // 5b: asynchronous reset mid-capture
        arm(2'd0, 16'd8);
        beat(1'b1, 32'h51);
        beat(1'b1, 32'h52);
        aresetn = 1'b0;
        #1;
        chk("ar_tready", {31'd0, data_stream_TREADY}, 32'd0);
        chk("ar_en",     {31'd0, bram_EN}, 32'd0);
        chk("ar_we",     {28'd0, bram_WE}, 32'd0);
        chk("ar_addr",   bram_ADDR, 32'd0);
        chk("ar_din",    bram_DIN, 32'd0);
        chk("ar_state",  {30'd0, stat_state}, 32'd0);
        chk("ar_words",  {16'd0, stat_words}, 32'd0);
        data_stream_TVALID = 1'b0;
        step();
        aresetn = 1'b1;
        step();
        chk("ar_tready_up", {31'd0, data_stream_TREADY}, 32'd1);

`ifdef STREAM_TO_BRAM_CONTINUOUS_EN
        // 6: ring buffer
        base = wr_cnt;
        cfg_continuous = 1'b1;
        arm(2'd0, 16'd4);
        cfg_continuous = 1'b0;
        for (int i = 0; i < 10; i++) beat(1'b1, 32'h60 + i);
        beat(1'b0, 32'h0);
        step(2);
        chk("t6_wrcnt", wr_cnt - base, 32'd10);
        for (int i = 0; i < 10; i++) chk("t6_addr", wr_addr[base+i], 32'((i % 4) * 4));
        chk("t6_m0", mem[0], 32'h68);
        chk("t6_m1", mem[1], 32'h69);
        chk("t6_m2", mem[2], 32'h66);
        chk("t6_m3", mem[3], 32'h67);
        chk("t6_words", {16'd0, stat_words}, 32'd4);
        chk("t6_state", {30'd0, stat_state}, 32'd2);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("t6_abort", {30'd0, stat_state}, 32'd0);
`endif

        chk("we_allornone", bad_we, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule : tb_stream_to_bram
`default_nettype wire
